npcnn_mc: RTL and testbench
===========================

Name: npcnn_mc

Overview:
- Parametrised multi-channel successor to the single-channel convolution engine.
- Loads a CH-channel A_SIZE x A_SIZE activation tile and a CH-channel F_SIZE x F_SIZE filter through a valid/ready load port.
- Computes the 2-D convolution summed across channels, with configurable stride, zero padding and optional ReLU.
- Streams each result out over a valid/ready output port. Sits between the tile buffer and the feature-map writer in the CNN datapath.

Parameters:
- A_SIZE, 6, activation tile edge length
- F_SIZE, 3, filter edge length
- STRIDE, 1, convolution stride (>=1)
- PAD, 0, zero-padding width on each edge
- CH, 2, number of input channels summed into each output
- DW, 8, activation width (unsigned)
- WW, 9, weight width (two's complement)
- ACC_W, 24, accumulator/output width; must be >= DW+WW+1+ceil(log2(CH*F_SIZE*F_SIZE))

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- go  in  1  start pulse, sampled only in IDLE
- relu_en  in  1  ReLU mode, latched at go
- ld_valid  in  1  load word valid
- ld_ready  out  1  high in LOAD_A/LOAD_F
- a_in  in  DW  activation word (used in LOAD_A)
- f_in  in  WW  weight word (used in LOAD_F)
- out  out  ACC_W  signed convolution result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Output edge: O = floor((A_SIZE+2*PAD-F_SIZE)/STRIDE)+1. Defaults give O=4. Outputs are produced in order oy, then ox (raster).
- Reset (reset=0, async): state=IDLE. out=0, out_valid=0, done=0, ld_ready=0, busy=0. All counters and the accumulator are cleared. Buffer contents are undefined; reset does not clear them.
- IDLE: go=1 latches relu_en, then goes to LOAD_A. go in any other state is ignored.
- LOAD_A: ld_ready=1. A transfer occurs when ld_valid and ld_ready are both high, and captures a_in. The first transfer is index 0. Order is channel, then row, then column. After CH*A_SIZE*A_SIZE transfers, go to LOAD_F.
- LOAD_F: same handshake, capturing f_in in channel, row, column order. After CH*F_SIZE*F_SIZE transfers, go to COMPUTE. ld_ready drops in the cycle after the last transfer.
- COMPUTE:
  - One MAC per cycle: acc += zext(a) * sext(f), giving signed ACC_W.
  - Iteration order is channel, then kernel row, then kernel column.
  - Input position = (oy*STRIDE+ky-PAD, ox*STRIDE+kx-PAD). Positions outside 0..A_SIZE-1 contribute 0.
  - Accumulator is cleared at the start of each output.
  - After CH*F_SIZE*F_SIZE MAC cycles, go to OUTPUT.
  - Latency from entering COMPUTE to out_valid is CH*F_SIZE*F_SIZE+1 cycles.
- OUTPUT:
  - out_valid=1. out = relu ? (acc<0 ? 0 : acc) : acc.
  - out and out_valid stay stable while out_ready=0.
  - On out_valid and out_ready: if more outputs remain, go to COMPUTE for the next position and drop out_valid. Otherwise go to DONE.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. out keeps its last value until the next result.
- Overflow: the accumulator wraps modulo 2^ACC_W. It does not saturate. The ACC_W legality rule above guarantees no wrap.
- ld_valid while ld_ready=0 is ignored and has no side effects.
- Reset asserted mid-operation aborts immediately. No done is issued, and the next go starts a fresh load.

Test Plan:
- Defaults, all activations=1, all weights=+1, out_ready=1 -> 16 outputs each =18, then done pulse; busy=0 after.
- PAD=1, defaults otherwise, all ones -> O=6; corners 8, non-corner edges 12, interior 18.
- A_SIZE=7, STRIDE=2, ramp activations a=index%256, weights=1 on center tap only -> O=3. Each output equals the activation at (2oy+1, 2ox+1), summed over both channels.
- Weights all -1 (9'h1FF), activations 255: relu_en=0 -> every out = -4590 (sign-extended). Rerun with relu_en=1 -> every out = 0.
- Backpressure: hold out_ready=0 for 5 cycles on the 3rd result -> out and out_valid constant, no extra results, total count still 16. Also drive ld_valid gaps during load -> identical results.
- Assert reset for 1 cycle during COMPUTE of output 7 -> all outputs 0 and state IDLE immediately, no done. A new go plus full reload yields correct 16 results.

Source files
------------

// File: rtl/npcnn_mc_if.sv
// Load and result streaming port of the multi-channel convolution engine.
// master = tile buffer / feature-map writer side, slave = npcnn_mc.
interface npcnn_mc_if #(
  parameter int DW    = 8,
  parameter int WW    = 9,
  parameter int ACC_W = 24
);
  logic                    ld_valid;
  logic                    ld_ready;
  logic [DW-1:0]           a_in;
  logic [WW-1:0]           f_in;
  logic signed [ACC_W-1:0] out;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output ld_valid, a_in, f_in, out_ready,
    input  ld_ready, out, out_valid
  );

  modport slave (
    input  ld_valid, a_in, f_in, out_ready,
    output ld_ready, out, out_valid
  );
endinterface

// File: rtl/npcnn_mc.sv
// Multi-channel 2-D convolution engine: loads a CH-channel activation tile and
// filter, then produces one channel-summed result per output position with
// configurable stride, zero padding and optional ReLU.
module npcnn_mc #(
  parameter int A_SIZE = 6,
  parameter int F_SIZE = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = 0,
  parameter int CH     = 2,
  parameter int DW     = 8,
  parameter int WW     = 9,
  parameter int ACC_W  = 24
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     go,
  input  logic     relu_en,
  npcnn_mc_if.slave bus,
  output logic     busy,
  output logic     done
);

  localparam int O_SIZE = (A_SIZE + 2 * PAD - F_SIZE) / STRIDE + 1;
  localparam int NA     = CH * A_SIZE * A_SIZE;
  localparam int NF     = CH * F_SIZE * F_SIZE;
  localparam int NL     = (NA > NF) ? NA : NF;
  localparam int LW     = $clog2(NL + 1);
  localparam int AW     = (NA > 1) ? $clog2(NA) : 1;
  localparam int FIW    = (NF > 1) ? $clog2(NF) : 1;
  localparam int CW     = (CH > 1) ? $clog2(CH) : 1;
  localparam int KW     = (F_SIZE > 1) ? $clog2(F_SIZE) : 1;
  localparam int OW     = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_F, S_COMPUTE, S_OUTPUT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0] a_buf [NA];
  logic [WW-1:0] f_buf [NF];

  logic [LW-1:0] ld_cnt;
  logic [CW-1:0] ch;
  logic [KW-1:0] ky, kx;
  logic [OW-1:0] oy, ox;

  logic signed [ACC_W-1:0] acc, out_r, prod, a_ext, f_ext, res;
  logic                    relu_r, out_valid_r;
  logic                    ld_ready, ld_xfer, out_xfer;
  logic                    ld_a_last, ld_f_last, mac_last, out_last;

  int            iy, ix;
  logic          in_range;
  logic [AW-1:0] a_idx;
  logic [FIW-1:0] f_idx;
  logic [DW-1:0] a_val;

  assign ld_ready  = (state == S_LOAD_A) || (state == S_LOAD_F);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign ld_xfer   = bus.ld_valid && ld_ready;
  assign out_xfer  = out_valid_r && bus.out_ready;

  assign ld_a_last = (ld_cnt == LW'(NA - 1));
  assign ld_f_last = (ld_cnt == LW'(NF - 1));
  assign mac_last  = (ch == CW'(CH - 1)) && (ky == KW'(F_SIZE - 1)) && (kx == KW'(F_SIZE - 1));
  assign out_last  = (oy == OW'(O_SIZE - 1)) && (ox == OW'(O_SIZE - 1));

  assign bus.ld_ready  = ld_ready;
  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (go) state_nx = S_LOAD_A;
      S_LOAD_A:  if (ld_xfer && ld_a_last) state_nx = S_LOAD_F;
      S_LOAD_F:  if (ld_xfer && ld_f_last) state_nx = S_COMPUTE;
      S_COMPUTE: if (mac_last) state_nx = S_OUTPUT;
      S_OUTPUT:  if (out_xfer) state_nx = out_last ? S_DONE : S_COMPUTE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Tap addressing: padded positions read as zero, then one signed MAC product.
  always_comb begin
    iy       = int'(oy) * STRIDE + int'(ky) - PAD;
    ix       = int'(ox) * STRIDE + int'(kx) - PAD;
    in_range = (iy >= 0) && (iy < A_SIZE) && (ix >= 0) && (ix < A_SIZE);
    a_idx    = '0;
    if (in_range) a_idx = AW'(int'(ch) * A_SIZE * A_SIZE + iy * A_SIZE + ix);
    f_idx    = FIW'(int'(ch) * F_SIZE * F_SIZE + int'(ky) * F_SIZE + int'(kx));
    a_val    = in_range ? a_buf[a_idx] : '0;
    a_ext    = ACC_W'(a_val);
    f_ext    = ACC_W'($signed(f_buf[f_idx]));
    prod     = a_ext * f_ext;
    res      = (relu_r && acc[ACC_W-1]) ? '0 : acc;
  end

  // Tile and filter storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_xfer && (state == S_LOAD_A)) a_buf[AW'(ld_cnt)] <= bus.a_in;
    if (ld_xfer && (state == S_LOAD_F)) f_buf[FIW'(ld_cnt)] <= bus.f_in;
  end

  // Load counter, kernel/output position counters, accumulator and result register.
  // The result register loads on the first OUTPUT cycle, which is what puts
  // out_valid one cycle after the final MAC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_cnt      <= '0;
      ch          <= '0;
      ky          <= '0;
      kx          <= '0;
      oy          <= '0;
      ox          <= '0;
      acc         <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      relu_r      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            relu_r <= relu_en;
            ld_cnt <= '0;
          end
        end
        S_LOAD_A: begin
          if (ld_xfer) ld_cnt <= ld_a_last ? '0 : ld_cnt + LW'(1);
        end
        S_LOAD_F: begin
          if (ld_xfer) begin
            ld_cnt <= ld_f_last ? '0 : ld_cnt + LW'(1);
            if (ld_f_last) begin
              acc <= '0;
              ch  <= '0;
              ky  <= '0;
              kx  <= '0;
              oy  <= '0;
              ox  <= '0;
            end
          end
        end
        S_COMPUTE: begin
          acc <= acc + prod;
          if (kx == KW'(F_SIZE - 1)) begin
            kx <= '0;
            if (ky == KW'(F_SIZE - 1)) begin
              ky <= '0;
              ch <= (ch == CW'(CH - 1)) ? '0 : ch + CW'(1);
            end else begin
              ky <= ky + KW'(1);
            end
          end else begin
            kx <= kx + KW'(1);
          end
        end
        S_OUTPUT: begin
          if (!out_valid_r) begin
            out_r       <= res;
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            acc         <= '0;
            if (ox == OW'(O_SIZE - 1)) begin
              ox <= '0;
              oy <= (oy == OW'(O_SIZE - 1)) ? '0 : oy + OW'(1);
            end else begin
              ox <= ox + OW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npcnn_mc.sv
// Directed bench for npcnn_mc: three configurations (defaults, PAD=1,
// A_SIZE=7/STRIDE=2) sharing one stimulus driver through a select mux.
module tb_npcnn_mc;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] sel = 2'd0;
  logic       go_s = 1'b0, relu_s = 1'b0, ld_valid_s = 1'b0, out_ready_s = 1'b1;
  logic [7:0] a_s = '0;
  logic [8:0] f_s = '0;

  logic busy0, busy1, busy2, done0, done1, done2;
  logic ld_ready_m, out_valid_m, busy_m, done_m;
  logic signed [23:0] out_m;

  npcnn_mc_if #(.DW(8), .WW(9), .ACC_W(24)) if0 ();
  npcnn_mc_if #(.DW(8), .WW(9), .ACC_W(24)) if1 ();
  npcnn_mc_if #(.DW(8), .WW(9), .ACC_W(24)) if2 ();

  assign if0.ld_valid = ld_valid_s && (sel == 2'd0);
  assign if1.ld_valid = ld_valid_s && (sel == 2'd1);
  assign if2.ld_valid = ld_valid_s && (sel == 2'd2);
  assign if0.a_in = a_s;  assign if1.a_in = a_s;  assign if2.a_in = a_s;
  assign if0.f_in = f_s;  assign if1.f_in = f_s;  assign if2.f_in = f_s;
  assign if0.out_ready = out_ready_s;
  assign if1.out_ready = out_ready_s;
  assign if2.out_ready = out_ready_s;

  npcnn_mc u0 (
    .clk(clk), .reset(reset), .go(go_s && (sel == 2'd0)), .relu_en(relu_s),
    .bus(if0), .busy(busy0), .done(done0)
  );
  npcnn_mc #(.PAD(1)) u1 (
    .clk(clk), .reset(reset), .go(go_s && (sel == 2'd1)), .relu_en(relu_s),
    .bus(if1), .busy(busy1), .done(done1)
  );
  npcnn_mc #(.A_SIZE(7), .STRIDE(2)) u2 (
    .clk(clk), .reset(reset), .go(go_s && (sel == 2'd2)), .relu_en(relu_s),
    .bus(if2), .busy(busy2), .done(done2)
  );

  always_comb begin
    ld_ready_m = if0.ld_ready; out_valid_m = if0.out_valid; out_m = if0.out;
    busy_m = busy0; done_m = done0;
    case (sel)
      2'd1: begin
        ld_ready_m = if1.ld_ready; out_valid_m = if1.out_valid; out_m = if1.out;
        busy_m = busy1; done_m = done1;
      end
      2'd2: begin
        ld_ready_m = if2.ld_ready; out_valid_m = if2.out_valid; out_m = if2.out;
        busy_m = busy2; done_m = done2;
      end
      default: ;
    endcase
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus patterns: apat 0 = ones, 1 = ramp, 2 = 255; wpat 0 = +1, 1 = centre tap, 2 = -1.
  function automatic int aval(input int p, input int idx);
    case (p)
      1:       return idx % 256;
      2:       return 255;
      default: return 1;
    endcase
  endfunction

  function automatic int wval(input int p, input int idx);
    case (p)
      1:       return ((idx % 9) == 4) ? 1 : 0;
      2:       return -1;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_a(input int s);  return (s == 2) ? 7 : 6; endfunction
  function automatic int cfg_o(input int s);  return (s == 1) ? 6 : ((s == 2) ? 3 : 4); endfunction

  // Reference convolution straight from the definition.
  function automatic int model(input int s, input int ap, input int wp, input bit relu,
                               input int oy, input int ox);
    int a, p, st, acc, iy, ix;
    a = cfg_a(s);
    p = (s == 1) ? 1 : 0;
    st = (s == 2) ? 2 : 1;
    acc = 0;
    for (int c = 0; c < 2; c++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          iy = oy * st + ky - p;
          ix = ox * st + kx - p;
          if (iy >= 0 && iy < a && ix >= 0 && ix < a)
            acc += aval(ap, c * a * a + iy * a + ix) * wval(wp, c * 9 + ky * 3 + kx);
        end
    if (relu && acc < 0) acc = 0;
    return acc;
  endfunction

  typedef struct {
    int sel; int apat; int wpat; bit relu; bit gaps; bit bp;
    int exp_n; int exp_first; int exp_last;
  } vec_t;

  vec_t tbl[6];

  task automatic do_load(input vec_t r);
    int idx, na, total, guard, w;
    bit v;
    sel = 2'(r.sel);
    relu_s = r.relu;
    out_ready_s = 1'b1;
    na = 2 * cfg_a(r.sel) * cfg_a(r.sel);
    total = na + 18;
    // Stray load words while idle must be ignored.
    @(negedge clk); ld_valid_s = 1'b1; a_s = 8'hAA; f_s = 9'h0AA;
    @(negedge clk); go_s = 1'b1;
    @(negedge clk); go_s = 1'b0; relu_s = ~r.relu;
    idx = 0;
    guard = 0;
    while (idx < total && guard < 2000) begin
      v = !(r.gaps && (guard % 3 == 1));
      ld_valid_s = v;
      a_s = v ? 8'(aval(r.apat, (idx < na) ? idx : 0)) : 8'h5A;
      w = (idx >= na) ? wval(r.wpat, idx - na) : 0;
      f_s = v ? w[8:0] : 9'h155;
      if (v && ld_ready_m) idx++;
      @(negedge clk);
      guard++;
    end
    check("load_count", idx, total);
    ld_valid_s = 1'b0;
    check("ld_ready_drop", int'(ld_ready_m), 0);
  endtask

  task automatic run_case(input vec_t r, input int id);
    int lat, n, ndone, hv, o;
    bit held;
    do_load(r);
    o = cfg_o(r.sel);
    lat = 0;
    while (!out_valid_m && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("c%0d_latency", id), lat, 19);
    n = 0;
    ndone = 0;
    held = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (done_m) ndone++;
      if (ndone > 0 && !done_m) break;
      if (out_valid_m) begin
        if (r.bp && n == 2 && !held) begin
          held = 1'b1;
          hv = int'(out_m);
          out_ready_s = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("c%0d_bp_valid", id), int'(out_valid_m), 1);
            check($sformatf("c%0d_bp_hold", id), int'(out_m), hv);
          end
          out_ready_s = 1'b1;
        end
        if (n < r.exp_n)
          check($sformatf("c%0d_out%0d", id, n), int'(out_m),
                model(r.sel, r.apat, r.wpat, r.relu, n / o, n % o));
        if (n == 0) check($sformatf("c%0d_first", id), int'(out_m), r.exp_first);
        if (n == r.exp_n - 1) check($sformatf("c%0d_last", id), int'(out_m), r.exp_last);
        n++;
      end
      @(negedge clk);
    end
    check($sformatf("c%0d_count", id), n, r.exp_n);
    check($sformatf("c%0d_done_cycles", id), ndone, 1);
    check($sformatf("c%0d_busy_after", id), int'(busy_m), 0);
    check($sformatf("c%0d_out_kept", id), int'(out_m), r.exp_last);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    tbl[0] = '{sel: 0, apat: 0, wpat: 0, relu: 0, gaps: 0, bp: 0, exp_n: 16, exp_first: 18,    exp_last: 18};
    tbl[1] = '{sel: 1, apat: 0, wpat: 0, relu: 0, gaps: 0, bp: 0, exp_n: 36, exp_first: 8,     exp_last: 8};
    tbl[2] = '{sel: 2, apat: 1, wpat: 1, relu: 0, gaps: 0, bp: 0, exp_n: 9,  exp_first: 65,    exp_last: 129};
    tbl[3] = '{sel: 0, apat: 2, wpat: 2, relu: 0, gaps: 0, bp: 0, exp_n: 16, exp_first: -4590, exp_last: -4590};
    tbl[4] = '{sel: 0, apat: 2, wpat: 2, relu: 1, gaps: 0, bp: 0, exp_n: 16, exp_first: 0,     exp_last: 0};
    tbl[5] = '{sel: 0, apat: 0, wpat: 0, relu: 0, gaps: 1, bp: 1, exp_n: 16, exp_first: 18,    exp_last: 18};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rst%0d_out", s), int'(out_m), 0);
      check($sformatf("rst%0d_out_valid", s), int'(out_valid_m), 0);
      check($sformatf("rst%0d_done", s), int'(done_m), 0);
      check($sformatf("rst%0d_ld_ready", s), int'(ld_ready_m), 0);
      check($sformatf("rst%0d_busy", s), int'(busy_m), 0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_case(tbl[i], i);

    // Abort during COMPUTE of output 7, then a fresh run must be clean.
    do_load(tbl[0]);
    n = 0;
    for (int cyc = 0; cyc < 1000 && n < 7; cyc++) begin
      if (out_valid_m) n++;
      @(negedge clk);
    end
    check("abort_reached_7", n, 7);
    repeat (5) @(negedge clk);
    check("abort_busy_before", int'(busy_m), 1);
    reset = 1'b0;
    #1;
    check("abort_out", int'(out_m), 0);
    check("abort_out_valid", int'(out_valid_m), 0);
    check("abort_busy", int'(busy_m), 0);
    check("abort_ld_ready", int'(ld_ready_m), 0);
    check("abort_done", int'(done_m), 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_m || out_valid_m || busy_m) seen++;
    end
    check("abort_stays_idle", seen, 0);
    run_case(tbl[0], 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
